// File: rtl/uart_loopback_core.sv
// UART transceiver core: TX FIFO -> serializer -> (loopback or pin) -> deserializer -> RX FIFO.
// Frames are start, DATA_BITS data LSB first, optional parity, one stop bit.
module uart_loopback_core #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_en,
    input  logic [DATA_BITS-1:0] d_in,
    input  logic                 r_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rd_valid,
    input  logic                 loop_en,
    input  logic                 rx_in,
    output logic                 tx_out,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic                 rx_empty,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 clr_err,
    output logic [2:0]           dbg_tx_state,
    output logic [2:0]           dbg_rx_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] CLK_HALF = CLK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             HAS_PAR  = (PARITY_EN != 0);
    localparam logic             ODD_PAR  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_tx_wptr;
    logic [PTR_W-1:0]     r_tx_rptr;
    logic [CNT_W-1:0]     r_tx_cnt;
    tx_state_t            r_tx_state;

    logic                 w_tx_empty;
    logic                 w_tx_full;
    logic                 w_tx_pop;
    logic                 w_tx_push;
    logic [DATA_BITS-1:0] w_tx_head;

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == CNT_FULL);
    assign w_tx_pop   = (r_tx_state == TX_IDLE) && !w_tx_empty;
    // A pop in the same cycle frees a slot, so a write while full is still accepted.
    assign w_tx_push  = w_en && (!w_tx_full || w_tx_pop);
    assign w_tx_head  = r_tx_mem[r_tx_rptr];

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= d_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + 1'b1;
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + 1'b1;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // ---------------- TX serializer ----------------
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic [CLK_W-1:0]     r_tx_clk;
    logic [BIT_W-1:0]     r_tx_bit;
    logic                 r_tx_out;

    // tx_out is registered from the current state, so the line lags the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_clk   <= '0;
            r_tx_bit   <= '0;
            r_tx_out   <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_out <= 1'b1;
                    r_tx_clk <= '0;
                    r_tx_bit <= '0;
                    if (!w_tx_empty) begin
                        r_tx_shift <= w_tx_head;
                        r_tx_par   <= (^w_tx_head) ^ ODD_PAR;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    r_tx_out <= 1'b0;
                    if (r_tx_clk == CLK_LAST) begin
                        r_tx_clk   <= '0;
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_clk <= r_tx_clk + 1'b1;
                    end
                end
                TX_DATA: begin
                    r_tx_out <= r_tx_shift[0];
                    if (r_tx_clk == CLK_LAST) begin
                        r_tx_clk   <= '0;
                        r_tx_shift <= r_tx_shift >> 1;
                        if (r_tx_bit == BIT_LAST) begin
                            r_tx_bit   <= '0;
                            r_tx_state <= HAS_PAR ? TX_PARITY : TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                        end
                    end else begin
                        r_tx_clk <= r_tx_clk + 1'b1;
                    end
                end
                TX_PARITY: begin
                    r_tx_out <= r_tx_par;
                    if (r_tx_clk == CLK_LAST) begin
                        r_tx_clk   <= '0;
                        r_tx_state <= TX_STOP;
                    end else begin
                        r_tx_clk <= r_tx_clk + 1'b1;
                    end
                end
                TX_STOP: begin
                    r_tx_out <= 1'b1;
                    if (r_tx_clk == CLK_LAST) begin
                        r_tx_clk   <= '0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_clk <= r_tx_clk + 1'b1;
                    end
                end
                default: begin
                    r_tx_out   <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // ---------------- RX synchronizer ----------------
    logic w_rx_line;
    logic r_sync1;
    logic r_sync2;
    logic r_sync_prev;

    assign w_rx_line = loop_en ? r_tx_out : rx_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync1     <= w_rx_line;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    // ---------------- RX deserializer ----------------
    rx_state_t            r_rx_state;
    logic [CLK_W-1:0]     r_rx_clk;
    logic [BIT_W-1:0]     r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;

    logic w_rx_sample;
    logic w_rx_done;
    logic w_par_err_set;
    logic w_frame_err_set;

    assign w_rx_sample     = (r_rx_clk == CLK_LAST);
    assign w_rx_done       = (r_rx_state == RX_STOP) && w_rx_sample;
    assign w_par_err_set   = (r_rx_state == RX_PARITY) && w_rx_sample &&
                             (r_sync2 != ((^r_rx_shift) ^ ODD_PAR));
    assign w_frame_err_set = w_rx_done && !r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_clk   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_clk <= '0;
                    r_rx_bit <= '0;
                    if (r_sync_prev && !r_sync2) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Half-bit check rejects glitches shorter than half a bit.
                    if (r_rx_clk == CLK_HALF) begin
                        r_rx_clk   <= '0;
                        r_rx_state <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_clk <= r_rx_clk + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_sample) begin
                        r_rx_clk   <= '0;
                        r_rx_shift <= {r_sync2, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == BIT_LAST) begin
                            r_rx_bit   <= '0;
                            r_rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_clk <= r_rx_clk + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (w_rx_sample) begin
                        r_rx_clk   <= '0;
                        r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_clk <= r_rx_clk + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_sample) begin
                        r_rx_clk   <= '0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_clk <= r_rx_clk + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO and read port ----------------
    // Read handshake: r_en is a request honoured only when rx_empty=0; each honoured
    // request yields exactly one rd_valid pulse with data_out on the following cycle.
    logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_rx_wptr;
    logic [PTR_W-1:0]     r_rx_rptr;
    logic [CNT_W-1:0]     r_rx_cnt;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_rd_valid;

    logic w_rx_empty;
    logic w_rx_full;
    logic w_rx_pop;
    logic w_rx_push;
    logic w_overrun_set;

    assign w_rx_empty    = (r_rx_cnt == '0);
    assign w_rx_full     = (r_rx_cnt == CNT_FULL);
    assign w_rx_pop      = r_en && !w_rx_empty;
    assign w_rx_push     = w_rx_done && (!w_rx_full || w_rx_pop);
    assign w_overrun_set = w_rx_done && w_rx_full && !w_rx_pop;

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= r_rx_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_cnt   <= '0;
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rx_pop;
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rptr  <= r_rx_rptr + 1'b1;
                r_data_out <= r_rx_mem[r_rx_rptr];
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // ---------------- sticky error flags ----------------
    logic r_parity_err;
    logic r_frame_err;
    logic r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (clr_err) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_parity_err <= r_parity_err | w_par_err_set;
            r_frame_err  <= r_frame_err  | w_frame_err_set;
            r_overrun    <= r_overrun    | w_overrun_set;
        end
    end

    assign data_out     = r_data_out;
    assign rd_valid     = r_rd_valid;
    assign tx_out       = r_tx_out;
    assign tx_full      = w_tx_full;
    assign tx_busy      = (r_tx_state != TX_IDLE) || !w_tx_empty;
    assign rx_empty     = w_rx_empty;
    assign parity_err   = r_parity_err;
    assign frame_err    = r_frame_err;
    assign overrun      = r_overrun;
    assign dbg_tx_state = r_tx_state;
    assign dbg_rx_state = r_rx_state;

endmodule

// File: tb/tb_uart_loopback_core.sv
// Bench for uart_loopback_core: a loopback instance without parity and an
// external-line instance with odd parity, checked against hand-computed values.
module tb_uart_loopback_core;

    localparam int DW    = 8;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance: no parity
    logic          w_en = 1'b0;
    logic [DW-1:0] d_in = '0;
    logic          r_en = 1'b0;
    logic          loop_en = 1'b1;
    logic          rx_in = 1'b1;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_out;
    logic          rd_valid, tx_out, tx_full, tx_busy, rx_empty;
    logic          parity_err, frame_err, overrun;
    logic [2:0]    dbg_tx_state, dbg_rx_state;

    // parity instance: odd parity, driven from rx_in_p
    logic          w_en_p = 1'b0;
    logic [DW-1:0] d_in_p = '0;
    logic          r_en_p = 1'b0;
    logic          loop_en_p = 1'b0;
    logic          rx_in_p = 1'b1;
    logic          clr_err_p = 1'b0;
    logic [DW-1:0] data_out_p;
    logic          rd_valid_p, tx_out_p, tx_full_p, tx_busy_p, rx_empty_p;
    logic          parity_err_p, frame_err_p, overrun_p;
    logic [2:0]    dbg_tx_state_p, dbg_rx_state_p;

    uart_loopback_core #(
        .DATA_BITS(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .d_in(d_in), .r_en(r_en),
        .data_out(data_out), .rd_valid(rd_valid), .loop_en(loop_en), .rx_in(rx_in),
        .tx_out(tx_out), .tx_full(tx_full), .tx_busy(tx_busy), .rx_empty(rx_empty),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
        .clr_err(clr_err), .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
    );

    uart_loopback_core #(
        .DATA_BITS(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)
    ) dut_p (
        .clk(clk), .rst(rst), .w_en(w_en_p), .d_in(d_in_p), .r_en(r_en_p),
        .data_out(data_out_p), .rd_valid(rd_valid_p), .loop_en(loop_en_p), .rx_in(rx_in_p),
        .tx_out(tx_out_p), .tx_full(tx_full_p), .tx_busy(tx_busy_p), .rx_empty(rx_empty_p),
        .parity_err(parity_err_p), .frame_err(frame_err_p), .overrun(overrun_p),
        .clr_err(clr_err_p), .dbg_tx_state(dbg_tx_state_p), .dbg_rx_state(dbg_rx_state_p)
    );

    // ---------------- scoreboard ----------------
    int            n_pass  = 0;
    int            n_total = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_p_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL rd_extra: got data 0x%0h, expected no read", data_out);
            end else begin
                check("rd_data", data_out, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rd_valid_p === 1'b1) begin
            if (exp_p_q.size() == 0) begin
                n_total++;
                $display("FAIL rd_extra_p: got data 0x%0h, expected no read", data_out_p);
            end else begin
                check("rd_data_p", data_out_p, exp_p_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_word();
        r_en = 1'b1;
        @(negedge clk);
        r_en = 1'b0;
        check("rd_valid_pulse", rd_valid, 1);
        @(negedge clk);
        check("rd_valid_clear", rd_valid, 0);
    endtask

    task automatic read_word_p();
        r_en_p = 1'b1;
        @(negedge clk);
        r_en_p = 1'b0;
        check("rd_valid_pulse_p", rd_valid_p, 1);
        @(negedge clk);
        check("rd_valid_clear_p", rd_valid_p, 0);
    endtask

    task automatic pulse_clr(input logic to_p);
        if (to_p) clr_err_p = 1'b1; else clr_err = 1'b1;
        @(negedge clk);
        clr_err_p = 1'b0;
        clr_err   = 1'b0;
    endtask

    // Drives one frame bit by bit on rx_in (or rx_in_p), then one idle bit.
    task automatic send_rx(input logic [7:0] d, input logic par_en, input logic par_bit,
                           input logic stop_bit, input logic to_p);
        logic [10:0] bits;
        int          n;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        if (par_en) begin
            bits[9]  = par_bit;
            bits[10] = stop_bit;
            n = 11;
        end else begin
            bits[9] = stop_bit;
            n = 10;
        end
        for (int b = 0; b < n; b++) begin
            if (to_p) rx_in_p = bits[b]; else rx_in = bits[b];
            tick(CPB);
        end
        rx_in_p = 1'b1;
        rx_in   = 1'b1;
        tick(CPB);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tx_out"},     tx_out, 1);
        check({tag, "_data_out"},   data_out, 0);
        check({tag, "_rd_valid"},   rd_valid, 0);
        check({tag, "_tx_full"},    tx_full, 0);
        check({tag, "_tx_busy"},    tx_busy, 0);
        check({tag, "_rx_empty"},   rx_empty, 1);
        check({tag, "_parity_err"}, parity_err, 0);
        check({tag, "_frame_err"},  frame_err, 0);
        check({tag, "_overrun"},    overrun, 0);
        check({tag, "_tx_state"},   dbg_tx_state, 0);
        check({tag, "_rx_state"},   dbg_rx_state, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         mism;
        logic [9:0] fr;

        tick(3);
        check_reset("por");
        check("por_tx_out_p",   tx_out_p, 1);
        check("por_tx_busy_p",  tx_busy_p, 0);
        check("por_tx_full_p",  tx_full_p, 0);
        check("por_overrun_p",  overrun_p, 0);
        check("por_rx_empty_p", rx_empty_p, 1);
        check("por_states_p",   {dbg_tx_state_p, dbg_rx_state_p}, 0);
        rst = 1'b0;
        tick(2);

        // 1: single loopback word, exact start latency and frame shape
        w_en = 1'b1; d_in = 8'hD4;
        exp_q.push_back(8'hD4);
        @(negedge clk);
        w_en = 1'b0;
        @(negedge clk);
        check("t1_tx_idle_at_n1", tx_out, 1);
        fr   = {1'b1, 8'hD4, 1'b0};
        mism = 0;
        for (int j = 2; j <= 161; j++) begin
            @(negedge clk);
            if (j == 2) check("t1_tx_start_at_n2", tx_out, 0);
            if (tx_out !== fr[(j-2)/16]) mism++;
            if (j == 160) check("t1_busy_last", tx_busy, 1);
            if (j == 161) check("t1_busy_done", tx_busy, 0);
        end
        check("t1_frame_bits", mism, 0);
        tick(39);
        check("t1_rx_not_empty", rx_empty, 0);
        read_word();
        check("t1_rx_empty", rx_empty, 1);
        check("t1_flags", {parity_err, frame_err, overrun}, 0);

        // 2: burst of writes; 5th accepted because the FSM popped, 6th dropped while full
        for (int k = 1; k <= 5; k++) exp_q.push_back(8'(k));
        for (int j = 0; j < 950; j++) begin
            w_en = (j < 6);
            d_in = 8'(j + 1);
            r_en = !rx_empty;
            @(negedge clk);
            if (j == 4)   check("t2_full_after_5th", tx_full, 1);
            if (j == 804) check("t2_busy_b2b", tx_busy, 1);
            if (j == 805) check("t2_busy_end", tx_busy, 0);
        end
        w_en = 1'b0;
        r_en = 1'b0;
        tick(2);
        check("t2_rx_empty", rx_empty, 1);
        check("t2_flags", {parity_err, frame_err, overrun}, 0);

        // 3: overrun with 5 frames and no reads
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        for (int k = 1; k <= 5; k++) begin
            w_en = 1'b1;
            d_in = 8'(k * 8'h11);
            @(negedge clk);
        end
        w_en = 1'b0;
        tick(950);
        check("t3_overrun", overrun, 1);
        check("t3_rx_not_empty", rx_empty, 0);
        check("t3_other_flags", {parity_err, frame_err}, 0);
        pulse_clr(1'b0);
        check("t3_overrun_clr", overrun, 0);
        for (int k = 0; k < 4; k++) read_word();
        check("t3_rx_empty", rx_empty, 1);

        // 4: odd parity on external line; 0xA5 has four ones so the correct bit is 1
        exp_p_q.push_back(8'hA5);
        send_rx(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        check("t4_parity_err", parity_err_p, 1);
        check("t4_frame_ok", frame_err_p, 0);
        read_word_p();
        pulse_clr(1'b1);
        check("t4_parity_clr", parity_err_p, 0);
        exp_p_q.push_back(8'hA5);
        send_rx(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
        check("t4_parity_good", parity_err_p, 0);
        read_word_p();
        exp_p_q.push_back(8'h07);
        send_rx(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        check("t4_parity_good_07", parity_err_p, 0);
        read_word_p();
        check("t4_rx_empty", rx_empty_p, 1);

        // 5: frame error still pushes the word; a short glitch is ignored
        loop_en = 1'b0;
        tick(4);
        exp_q.push_back(8'h5A);
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_frame_err", frame_err, 1);
        check("t5_parity_ok", parity_err, 0);
        check("t5_pushed", rx_empty, 0);
        read_word();
        pulse_clr(1'b0);
        check("t5_frame_clr", frame_err, 0);
        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        tick(40);
        check("t5_glitch_no_push", rx_empty, 1);
        check("t5_glitch_no_flags", {parity_err, frame_err, overrun}, 0);
        exp_q.push_back(8'h96);
        send_rx(8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_after_glitch", rx_empty, 0);
        read_word();

        // 6: reset during data bit 3 of 0x81, then clean loopback of 0x3C
        loop_en = 1'b1;
        tick(4);
        w_en = 1'b1; d_in = 8'h81;
        @(negedge clk);
        w_en = 1'b0;
        tick(70);
        check("t6_mid_data_low", tx_out, 0);
        #2 rst = 1'b1;
        #1 check("t6_async_tx_out", tx_out, 1);
        tick(2);
        check_reset("mid");
        rst = 1'b0;
        tick(200);
        check("t6_partial_lost", rx_empty, 1);
        w_en = 1'b1; d_in = 8'h3C;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        w_en = 1'b0;
        tick(200);
        check("t6_rx_not_empty", rx_empty, 0);
        check("t6_flags", {parity_err, frame_err, overrun}, 0);
        read_word();

        tick(5);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp_p_q_drained", exp_p_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
